hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Central pipeline controller that drives the enable and flush inputs of the four pipeline_register instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Resolves these hazards:
  - load-use stalls
  - taken-branch/jump squash (resolved in MEM)
  - instruction and data memory wait
  - halt.
- Flush outputs feed the registers' asynchronous clear. They are therefore decoded only from the state register (Moore), never from raw inputs, so they are glitch-free.

Parameters:
- none. Penalties are fixed by the state machine: load-use = 2 cycles, squash = 1 cycle.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returned valid data this cycle
- dhit  in  1  data memory completed access this cycle
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- idex_rt  in  5  rt (load destination) of instruction in ID/EX
- idex_dREN  in  1  ID/EX instruction is a load
- exmem_dREN  in  1  EX/MEM instruction reads data memory
- exmem_dWEN  in  1  EX/MEM instruction writes data memory
- exmem_redirect  in  1  EX/MEM holds taken branch or jump; PC is loading the target this cycle
- memwb_halt  in  1  halt instruction reached MEM/WB
- pc_en  out  1  PC write enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  pipeline register async clears
- halt  out  1  processor halted, sticky

Behaviour:
- States (hazard_state_t): RUN, BUBBLE, SQUASH, HALTED. The state register is cleared asynchronously to RUN.
- While nRST=0, every output is 0.
- dwait = (exmem_dREN | exmem_dWEN) & ~dhit.
- fwait = ~ihit, evaluated in RUN only.
- Global freeze (highest priority after HALTED):
  - Applies in any non-HALTED state when dwait=1, or in RUN when fwait=1.
  - All *_en are 0 and the state holds.
  - Flushes keep their state-decoded value. A held flush keeps its register at zero; this is harmless.
- HALTED:
  - Entered from any state at the edge where memwb_halt=1. This has priority over every other transition, including a freeze.
  - All en=0, all flush=0, halt=1.
  - Exits only on reset.
- RUN, no freeze, exmem_redirect=1:
  - All en=1.
  - Next state is SQUASH.
  - Redirect takes priority over load-use.
- RUN, no freeze, load-use:
  - Load-use = idex_dREN & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
  - pc_en=0 and ifid_en=0; idex_en, exmem_en, memwb_en = 1.
  - Next state is BUBBLE.
- RUN otherwise: all en=1, all flush=0.
- BUBBLE:
  - idex_flush=1; pc_en=0, ifid_en=0, idex_en=0; exmem_en=1, memwb_en=1.
  - Next state is RUN.
  - Net effect: the dependent instruction is reissued from IF/ID; penalty is 2 cycles.
- SQUASH:
  - ifid_flush, idex_flush, exmem_flush = 1; pc_en=0; the matching en=0; memwb_en=1.
  - Next state is RUN.
  - pc_en is held 0 because the fetched target would otherwise be lost under the asserted clear.
- memwb_flush is always 0. It is reserved and kept for interface symmetry.
- Simultaneous redirect and load-use: redirect wins, because the dependent instruction is wrong-path.
- Reset mid-stall: return to RUN with all outputs 0 until nRST is released.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds two outputs: stall_cnt (out, 32) and squash_cnt (out, 32).
  - stall_cnt increments on every freeze or BUBBLE cycle.
  - squash_cnt increments on every SQUASH entry.
  - Both saturate at 0xFFFFFFFF, reset to 0, and freeze in HALTED.
- Undefined: no counter ports or logic.

Decomposition:
- Add to cpu_types_pkg:
  - hazard_state_t enum (2 bits)
  - REG_ZERO constant (5'd0)
- One combinational sub-module, load_use_detect. Inputs: ifid_rs, ifid_rt, idex_rt, idex_dREN. Output: stall request.
- The FSM and output decode stay in hazard_control_unit.

Test Plan:
- Reset then release with ihit=1, no hazards -> all en=1, all flush=0, halt=0 from the first cycle after reset.
- idex_dREN=1, idex_rt=5, ifid_rs=5 -> cycle N: pc_en=0, ifid_en=0, idex_en=1. Cycle N+1: BUBBLE with idex_flush=1. Cycle N+2: RUN, all en=1.
- Same as above but idex_rt=0 -> no stall; all en=1.
- exmem_redirect=1 at cycle N -> cycle N+1: ifid/idex/exmem_flush=1, pc_en=0, memwb_en=1. Cycle N+2: RUN.
- exmem_dWEN=1 with dhit=0 for 3 cycles while in BUBBLE -> all en=0 for 3 cycles, idex_flush stays 1, state resumes to RUN after dhit.
- memwb_halt=1 during a dwait freeze -> next cycle halt=1, all en=0; stays so until nRST pulse. With HAZARD_PERF_EN, counters hold.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard controller state encoding and register-file constants.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      SQUASH = 2'd2,
      HALTED = 2'd3
   } hazard_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the instruction in IF/ID.
import cpu_types_pkg::*;

module load_use_detect (
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic [4:0] idex_rt,
   input  logic       idex_dREN,
   output logic       stall_req
);

   always_comb begin
      stall_req = idex_dREN && (idex_rt != REG_ZERO) &&
                  ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: stalls, squashes, memory-wait freeze and sticky halt.
// Optional build macro HAZARD_PERF_EN adds saturating stall/squash counters.
import cpu_types_pkg::*;

module hazard_control_unit (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic [4:0]  ifid_rs,
   input  logic [4:0]  ifid_rt,
   input  logic [4:0]  idex_rt,
   input  logic        idex_dREN,
   input  logic        exmem_dREN,
   input  logic        exmem_dWEN,
   input  logic        exmem_redirect,
   input  logic        memwb_halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        memwb_flush,
`ifdef HAZARD_PERF_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] squash_cnt,
`endif
   output logic        halt
);

   hazard_state_t state_q, state_d;
   logic lu_stall, dwait, freeze;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;

   load_use_detect u_lu (
      .ifid_rs   (ifid_rs),
      .ifid_rt   (ifid_rt),
      .idex_rt   (idex_rt),
      .idex_dREN (idex_dREN),
      .stall_req (lu_stall)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pc_en_c     = 1'b0;
      ifid_en_c   = 1'b0;
      idex_en_c   = 1'b0;
      exmem_en_c  = 1'b0;
      memwb_en_c  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halt        = 1'b0;

      dwait  = (exmem_dREN | exmem_dWEN) & ~dhit;
      freeze = (state_q != HALTED) && (dwait || (state_q == RUN && !ihit));

      // Flushes and halt depend on state_q alone; only enables see raw inputs.
      unique case (state_q)
         RUN: begin
            if (!freeze) begin
               if (exmem_redirect) begin
                  {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
                  state_d = SQUASH;
               end else if (lu_stall) begin
                  {idex_en_c, exmem_en_c, memwb_en_c} = '1;
                  state_d = BUBBLE;
               end else begin
                  {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
               end
            end
         end
         BUBBLE: begin
            idex_flush = 1'b1;
            if (!freeze) begin
               exmem_en_c = 1'b1;
               memwb_en_c = 1'b1;
               state_d    = RUN;
            end
         end
         SQUASH: begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (!freeze) begin
               memwb_en_c = 1'b1;
               state_d    = RUN;
            end
         end
         HALTED: halt = 1'b1;
         default: state_d = RUN;
      endcase

      if (memwb_halt) state_d = HALTED;
   end

   assign pc_en    = pc_en_c    & nRST;
   assign ifid_en  = ifid_en_c  & nRST;
   assign idex_en  = idex_en_c  & nRST;
   assign exmem_en = exmem_en_c & nRST;
   assign memwb_en = memwb_en_c & nRST;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, squash_cnt_q;
   logic        stall_inc, squash_inc;

   always_comb begin
      stall_inc  = (state_q != HALTED) && (freeze || state_q == BUBBLE);
      squash_inc = (state_q != SQUASH) && (state_d == SQUASH);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (stall_inc && stall_cnt_q != '1)   stall_cnt_q  <= stall_cnt_q + 32'd1;
         if (squash_inc && squash_cnt_q != '1) squash_cnt_q <= squash_cnt_q + 32'd1;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit with an expected-output scoreboard.
module tb_hazard_control_unit;

   logic CLK = 1'b0;
   logic nRST;
   logic ihit, dhit, idex_dREN, exmem_dREN, exmem_dWEN, exmem_redirect, memwb_halt;
   logic [4:0] ifid_rs, ifid_rt, idex_rt;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, squash_cnt;
   logic [31:0] stall_snap, squash_snap;
`endif

   int tests = 0;
   int fails = 0;

   logic [9:0] exp_q[$];
   string      tag_q[$];

   // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes, halt}
   localparam logic [9:0] E_OFF  = 10'b00000_0000_0;
   localparam logic [9:0] E_RUN  = 10'b11111_0000_0;
   localparam logic [9:0] E_LU   = 10'b00111_0000_0;
   localparam logic [9:0] E_BUB  = 10'b00011_0100_0;
   localparam logic [9:0] E_FBUB = 10'b00000_0100_0;
   localparam logic [9:0] E_SQ   = 10'b00001_1110_0;
   localparam logic [9:0] E_HALT = 10'b00000_0000_1;

   hazard_control_unit dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .ihit           (ihit),
      .dhit           (dhit),
      .ifid_rs        (ifid_rs),
      .ifid_rt        (ifid_rt),
      .idex_rt        (idex_rt),
      .idex_dREN      (idex_dREN),
      .exmem_dREN     (exmem_dREN),
      .exmem_dWEN     (exmem_dWEN),
      .exmem_redirect (exmem_redirect),
      .memwb_halt     (memwb_halt),
      .pc_en          (pc_en),
      .ifid_en        (ifid_en),
      .idex_en        (idex_en),
      .exmem_en       (exmem_en),
      .memwb_en       (memwb_en),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .exmem_flush    (exmem_flush),
      .memwb_flush    (memwb_flush),
`ifdef HAZARD_PERF_EN
      .stall_cnt      (stall_cnt),
      .squash_cnt     (squash_cnt),
`endif
      .halt           (halt)
   );

   always #5 CLK = ~CLK;

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0;
      idex_dREN = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
      exmem_redirect = 1'b0; memwb_halt = 1'b0;
      ifid_rs = 5'd1; ifid_rt = 5'd2; idex_rt = 5'd3;
   endtask

   // Inputs were just driven after a falling edge; record the expectation, then sample mid-low-phase.
   task automatic expect_out(input string tag, input logic [9:0] e);
      logic [9:0] obs, want;
      string      t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #2;
      obs  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", t, obs, want);
      end
   endtask

   task automatic next();
      @(negedge CLK);
      idle();
   endtask

   initial begin
      nRST = 1'b0;
      idle();
      @(negedge CLK);
      expect_out("reset_idle", E_OFF);
      next(); exmem_redirect = 1'b1; ihit = 1'b0;
      expect_out("reset_active_inputs", E_OFF);
      next(); nRST = 1'b1;
      expect_out("run_first", E_RUN);

      next(); idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
      expect_out("lu_rs_n", E_LU);
      next(); expect_out("lu_rs_bubble", E_BUB);
      next(); expect_out("lu_rs_run", E_RUN);

      next(); idex_dREN = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9;
      expect_out("lu_rt_n", E_LU);
      next(); ihit = 1'b0;
      expect_out("bubble_ignores_ihit", E_BUB);
      next(); expect_out("lu_rt_run", E_RUN);

      next(); idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      expect_out("lu_r0_no_stall", E_RUN);
      next(); idex_rt = 5'd7; ifid_rs = 5'd8; ifid_rt = 5'd6;
      expect_out("no_dep_no_stall", E_RUN);
      next(); idex_dREN = 1'b0; idex_rt = 5'd4; ifid_rs = 5'd4;
      expect_out("not_load_no_stall", E_RUN);

      next(); exmem_redirect = 1'b1; idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
      expect_out("redirect_wins", E_RUN);
      next(); ihit = 1'b0;
      expect_out("squash", E_SQ);
      next(); expect_out("squash_run", E_RUN);

      next(); ihit = 1'b0;
      expect_out("fwait_freeze", E_OFF);
      next(); exmem_redirect = 1'b1; ihit = 1'b0;
      expect_out("fwait_blocks_redirect", E_OFF);
      next(); expect_out("fwait_resume", E_RUN);

      next(); exmem_dREN = 1'b1;
      expect_out("dwait_run", E_OFF);
      next(); exmem_dREN = 1'b1; dhit = 1'b1;
      expect_out("dhit_run", E_RUN);

      next(); idex_dREN = 1'b1; idex_rt = 5'd12; ifid_rt = 5'd12;
      expect_out("lu_before_dwait", E_LU);
      for (int i = 0; i < 3; i++) begin
         next(); exmem_dWEN = 1'b1;
         expect_out("dwait_bubble", E_FBUB);
      end
      next(); exmem_dWEN = 1'b1; dhit = 1'b1;
      expect_out("dhit_bubble", E_BUB);
      next(); expect_out("dwait_bubble_run", E_RUN);

      next(); exmem_redirect = 1'b1;
      expect_out("redirect_pre_dwait", E_RUN);
      next(); exmem_dREN = 1'b1;
      expect_out("dwait_squash", E_SQ & 10'b00000_1111_1);
      next(); expect_out("squash_after_dwait", E_SQ);
      next(); expect_out("run_after_squash", E_RUN);

      next(); idex_dREN = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
      expect_out("lu_pre_reset", E_LU);
      next(); nRST = 1'b0;
      expect_out("reset_mid_bubble", E_OFF);
      next(); nRST = 1'b1;
      expect_out("run_after_reset", E_RUN);

      next(); exmem_dREN = 1'b1; memwb_halt = 1'b1;
      expect_out("halt_during_freeze", E_OFF);
`ifdef HAZARD_PERF_EN
      #1; stall_snap = stall_cnt; squash_snap = squash_cnt;
`endif
      next(); expect_out("halted", E_HALT);
      next(); exmem_redirect = 1'b1; exmem_dREN = 1'b1;
      expect_out("halted_redirect", E_HALT);
      next(); ihit = 1'b0; idex_dREN = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
      expect_out("halted_sticky", E_HALT);
`ifdef HAZARD_PERF_EN
      tests++;
      assert (stall_cnt === stall_snap + 32'd1) else begin
         fails++;
         $error("FAIL stall_cnt_hold observed=%0d expected=%0d", stall_cnt, stall_snap + 32'd1);
      end
      tests++;
      assert (squash_cnt === squash_snap) else begin
         fails++;
         $error("FAIL squash_cnt_hold observed=%0d expected=%0d", squash_cnt, squash_snap);
      end
`endif
      next(); nRST = 1'b0;
      expect_out("halt_reset", E_OFF);
      next(); nRST = 1'b1;
      expect_out("halt_cleared", E_RUN);

      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
